// File: rtl/multdiv_pkg.sv
// Shared types and constants for the ALU multdiv unit.
// Holds the FSM states, Booth select bundle and triplet codes.
package multdiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int ITERS     = DEF_WIDTH / 2;
  localparam int ACC_W     = DEF_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic two;
    logic neg;
  } booth_sel_t;

  localparam logic [2:0] BOOTH_Z0  = 3'b000;
  localparam logic [2:0] BOOTH_P1A = 3'b001;
  localparam logic [2:0] BOOTH_P1B = 3'b010;
  localparam logic [2:0] BOOTH_P2  = 3'b011;
  localparam logic [2:0] BOOTH_M2  = 3'b100;
  localparam logic [2:0] BOOTH_M1A = 3'b101;
  localparam logic [2:0] BOOTH_M1B = 3'b110;
  localparam logic [2:0] BOOTH_Z1  = 3'b111;

endpackage

// File: rtl/booth_encoder.sv
// Radix-4 Booth recoder: one multiplier triplet to a
// zero / double / negate select for the accumulator.
module booth_encoder
  import multdiv_pkg::*;
(
  input  logic [2:0] trip_i,
  output booth_sel_t sel_o
);

  always_comb begin
    sel_o = '0;
    unique case (1'b1)
      (trip_i == BOOTH_Z0),
      (trip_i == BOOTH_Z1): sel_o.zero = 1'b1;
      (trip_i == BOOTH_P1A),
      (trip_i == BOOTH_P1B): sel_o = '0;
      (trip_i == BOOTH_P2): sel_o.two = 1'b1;
      (trip_i == BOOTH_M2): begin
        sel_o.two = 1'b1;
        sel_o.neg = 1'b1;
      end
      (trip_i == BOOTH_M1A),
      (trip_i == BOOTH_M1B): sel_o.neg = 1'b1;
      default: sel_o.zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/multiplier_booth.sv
// Iterative signed radix-4 Booth multiplier, low-word result
// with signed-overflow flag; start/ready handshake as the divider.
module multiplier_booth
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int STEPS = (WIDTH == DEF_WIDTH) ? ITERS : WIDTH / 2;
  localparam int AW    = (WIDTH == DEF_WIDTH) ? ACC_W : WIDTH + 2;
  localparam int PW    = 2 * WIDTH + 3;
  localparam logic [4:0] LAST = 5'(STEPS - 1);

  state_e           state_q, state_d;
  logic [4:0]       count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    p_q, p_d;

  booth_sel_t         sel;
  logic [AW-1:0]      mag;
  logic [AW-1:0]      addend;
  logic               cin;
  logic [AW-1:0]      hi;
  logic signed [PW-1:0] step;

  booth_encoder u_enc (
    .trip_i (p_q[2:0]),
    .sel_o  (sel)
  );

  // -A / -2A as invert plus carry-in on the 34-bit accumulator
  always_comb begin
    mag    = sel.two ? {mcand_q[WIDTH-1], mcand_q, 1'b0}
                     : {{2{mcand_q[WIDTH-1]}}, mcand_q};
    addend = '0;
    cin    = 1'b0;
    if (!sel.zero) begin
      addend = sel.neg ? ~mag : mag;
      cin    = sel.neg;
    end
    hi   = p_q[PW-1:WIDTH+1] + addend + AW'(cin);
    step = $signed({hi, p_q[WIDTH:0]}) >>> 2;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        p_d     = step;
        count_d = count_q + 5'd1;
        if (count_q == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a start pulse aborts whatever is in flight
    if (ctrl_MULT) begin
      mcand_d = data_operandA;
      p_d     = {{(WIDTH + 2){1'b0}}, data_operandB, 1'b0};
      count_d = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
    end
  end

  assign data_result    = p_q[WIDTH:1];
  assign data_exception = ~((&p_q[PW-1:WIDTH]) | ~(|p_q[PW-1:WIDTH]));
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_multiplier_booth.sv
// Bench for multiplier_booth: directed corner vectors, random
// operands vs. an integer-product model, restart and reset cases.
module tb_multiplier_booth;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int failures = 0;

  multiplier_booth dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output logic exc);
    @(negedge clock);
    ctrl_MULT = 1'b1;
    opA = a;
    opB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    opA = $urandom;
    opB = $urandom;
    lat = -1;
    res = '0;
    exc = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = n;
        res = data_result;
        exc = data_exception;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (data_result !== 32'h0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=0", data_result);
    end
    checks++;
    if (data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags exc=%b rdy=%b exp=0/0",
               data_exception, data_resultRDY);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] va [5] = '{32'd7, 32'h80000000, 32'hFFFF0000,
                            32'h00010000, 32'h7FFFFFFF};
    logic [31:0] vb [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00008000,
                            32'h00010000, 32'd2};
    logic [31:0] er [5] = '{32'hFFFFFFEB, 32'h80000000, 32'h80000000,
                            32'h0, 32'hFFFFFFFE};
    logic        ee [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int lat;
    logic [31:0] res;
    logic exc;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], lat, res, exc);
      checks++;
      if (lat !== 16) begin
        failures++;
        $display("FAIL dir%0d_latency got=%0d exp=16", i, lat);
      end
      checks++;
      if (res !== er[i] || exc !== ee[i]) begin
        failures++;
        $display("FAIL dir%0d_value got=%h/%b exp=%h/%b",
                 i, res, exc, er[i], ee[i]);
      end
    end
    @(posedge clock);
    #1;
    checks++;
    if (data_resultRDY !== 1'b0 || data_result !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL rdy_pulse_hold rdy=%b res=%h exp=0/fffffffe",
               data_resultRDY, data_result);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [31:0] a, b, res, er;
    logic exc, ee;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = 32'($signed(16'($urandom)));
      if (i % 4 == 2) b = 32'($signed(8'($urandom)));
      model(a, b, er, ee);
      run_op(a, b, lat, res, exc);
      checks++;
      if (lat !== 16 || res !== er || exc !== ee) begin
        failures++;
        $display("FAIL rand%0d a=%h b=%h got=%h/%b lat=%0d exp=%h/%b lat=16",
                 i, a, b, res, exc, lat, er, ee);
      end
    end
  endtask

  task automatic test_restart;
    int pulses = 0;
    int first = -1;
    logic [31:0] res = '0;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    opA = 32'd3;
    opB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    @(negedge clock);
    ctrl_MULT = 1'b1;
    opA = 32'd6;
    opB = 32'd7;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    opA = 32'hDEADBEEF;
    opB = 32'h0BADF00D;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        pulses++;
        if (first < 0) begin
          first = n;
          res = data_result;
        end
      end
    end
    checks++;
    if (pulses !== 1 || first !== 16) begin
      failures++;
      $display("FAIL restart_rdy pulses=%0d at=%0d exp=1 at 16", pulses, first);
    end
    checks++;
    if (res !== 32'd42) begin
      failures++;
      $display("FAIL restart_result got=%0d exp=42", res);
    end
  endtask

  task automatic test_held_start;
    int first = -1;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    opA = 32'd9;
    opB = 32'd9;
    @(posedge clock);
    @(negedge clock);
    opA = 32'hFFFFFFF6;
    opB = 32'd11;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY && first < 0) first = n;
    end
    checks++;
    if (first !== 16 || data_result !== 32'hFFFFFF92) begin
      failures++;
      $display("FAIL held_start at=%0d res=%h exp=16/ffffff92",
               first, data_result);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    int lat;
    logic [31:0] res;
    logic exc;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    opA = 32'h7FFFFFFF;
    opB = 32'h7FFFFFFF;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 ||
        data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs res=%h exc=%b rdy=%b exp=0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL midreset_no_rdy pulses=%0d exp=0", pulses);
    end
    run_op(32'h12345678, 32'h0, lat, res, exc);
    checks++;
    if (lat !== 16 || res !== 32'h0 || exc !== 1'b0) begin
      failures++;
      $display("FAIL after_reset got=%h/%b lat=%0d exp=0/0 lat=16",
               res, exc, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] res, er;
    logic exc, ee;
    logic [31:0] a [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] b [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    for (int i = 0; i < 3; i++) begin
      model(a[i], b[i], er, ee);
      run_op(a[i], b[i], lat, res, exc);
      checks++;
      if (lat !== 16 || res !== er || exc !== ee) begin
        failures++;
        $display("FAIL b2b%0d got=%h/%b lat=%0d exp=%h/%b lat=16",
                 i, res, exc, lat, er, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_held_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
